// File: rtl/sync_inserter.sv
// Attached-sync-marker inserter: prefixes each codeword with SYNC_MARKER, forces the frame
// length to CODEWORD_LEN by padding or dropping, and packs the byte stream into 32-bit words.
module sync_inserter #(
    parameter logic [31:0] SYNC_MARKER  = 32'h1ACFFC1D,
    parameter int unsigned CODEWORD_LEN = 255,
    parameter logic [7:0]  FILL_BYTE    = 8'h55
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        frame_err_o
);

    typedef enum logic [2:0] {S_IDLE, S_MARKER, S_PASS, S_PAD, S_DROP} state_e;

    localparam logic [7:0] LenByte = 8'(CODEWORD_LEN);

    state_e      state_q;
    logic [1:0]  pack_cnt_q;
    logic [1:0]  mrk_idx_q;
    logic [23:0] shift_q;
    logic [7:0]  byte_cnt_q;

    logic        byte_ok;
    logic        accept;
    logic        push;
    logic [7:0]  push_byte;
    logic [7:0]  cnt_inc;
    logic        cnt_done;
    logic [31:0] marker_shift;

    // A 4th byte may only enter once the pending output word has gone or is leaving.
    assign byte_ok = (pack_cnt_q != 2'd3) || !data_valid_o || data_ready_i;
    assign s_axis_input_tready = ((state_q == S_PASS) && byte_ok) || (state_q == S_DROP);
    assign accept   = s_axis_input_tvalid && s_axis_input_tready;
    assign cnt_inc  = byte_cnt_q + 8'd1;
    assign cnt_done = (cnt_inc == LenByte);
    assign marker_shift = SYNC_MARKER >> {~mrk_idx_q, 3'b000};

    always_comb begin
        push      = 1'b0;
        push_byte = FILL_BYTE;
        unique case (state_q)
            S_IDLE:   push = !s_axis_input_tvalid && (pack_cnt_q != 2'd0) && byte_ok;
            S_MARKER: begin
                push      = byte_ok;
                push_byte = marker_shift[7:0];
            end
            S_PASS:   begin
                push      = accept;
                push_byte = s_axis_input_tdata;
            end
            S_PAD:    push = byte_ok;
            default:  push = 1'b0;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pack_cnt_q   <= 2'd0;
            mrk_idx_q    <= 2'd0;
            shift_q      <= 24'd0;
            byte_cnt_q   <= 8'd0;
            data_o       <= 32'd0;
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;

            if (push && (pack_cnt_q == 2'd3)) begin
                data_o       <= {shift_q, push_byte};
                data_valid_o <= 1'b1;
                pack_cnt_q   <= 2'd0;
            end else begin
                if (push) begin
                    shift_q    <= {shift_q[15:0], push_byte};
                    pack_cnt_q <= pack_cnt_q + 2'd1;
                end
                if (data_valid_o && data_ready_i) begin
                    data_valid_o <= 1'b0;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (s_axis_input_tvalid) begin
                        state_q   <= S_MARKER;
                        mrk_idx_q <= 2'd0;
                    end
                end
                S_MARKER: begin
                    if (byte_ok) begin
                        mrk_idx_q <= mrk_idx_q + 2'd1;
                        if (mrk_idx_q == 2'd3) begin
                            state_q    <= S_PASS;
                            byte_cnt_q <= 8'd0;
                        end
                    end
                end
                S_PASS: begin
                    if (accept) begin
                        byte_cnt_q <= cnt_inc;
                        if (cnt_done) begin
                            state_q     <= s_axis_input_tlast ? S_IDLE : S_DROP;
                            frame_err_o <= !s_axis_input_tlast;
                        end else if (s_axis_input_tlast) begin
                            state_q     <= S_PAD;
                            frame_err_o <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (byte_ok) begin
                        byte_cnt_q <= cnt_inc;
                        if (cnt_done) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (accept && s_axis_input_tlast) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
